// File: rtl/uart_rx_bit_timer_if.sv
// Configuration and timing strobe bundle between the RX control FSM (master)
// and the bit timer (slave).
interface uart_rx_bit_timer_if #(
    parameter int unsigned PRESCALE_W = 6
);
    logic                  enable;
    logic [3:0]            data_len;
    logic                  PAR_EN;
    logic                  STOP2;
    logic [PRESCALE_W-1:0] Prescale;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [3:0]            bit_cnt;
    logic                  sample_stb;
    logic [1:0]            sample_idx;
    logic                  bit_done;
    logic                  frame_done;
    logic                  cfg_err;

    modport master (
        output enable, data_len, PAR_EN, STOP2, Prescale,
        input  edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err
    );

    modport slave (
        input  enable, data_len, PAR_EN, STOP2, Prescale,
        output edge_cnt, bit_cnt, sample_stb, sample_idx, bit_done, frame_done, cfg_err
    );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// UART RX bit/edge timing generator: per-frame latched config, 3-point
// majority sample strobes, bit/frame done pulses and config error flag.
module uart_rx_bit_timer #(
    parameter int unsigned PRESCALE_W = 6,
    parameter int unsigned DATA_MAX   = 8,
    parameter int unsigned DATA_MIN   = 5
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_bit_timer_if.slave bt
);
    localparam int unsigned LEN_W = 4;
    localparam int unsigned BIT_W = 4;
    localparam int unsigned IDX_W = 2;
    localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);

    typedef enum logic [1:0] {IDLE, RUN, ERR} state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic                  par_q, par_d;
    logic                  stop2_q, stop2_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    logic                  cfg_ok_c;
    logic [BIT_W-1:0]      frame_bits_c;
    logic [PRESCALE_W-1:0] mid_c;
    logic                  last_edge_c;
    logic                  last_bit_c;
    logic                  sample_stb_c;
    logic [IDX_W-1:0]      sample_idx_c;
    logic                  bit_done_c;
    logic                  frame_done_c;

    // Legality of the config currently presented on the inputs
    assign cfg_ok_c = (bt.Prescale >= P_MIN) &&
                      (bt.data_len >= LEN_W'(DATA_MIN)) &&
                      (bt.data_len <= LEN_W'(DATA_MAX));

    // Start + data + optional parity + 1 or 2 stop bits, from latched config
    assign frame_bits_c = len_q + BIT_W'(2) + BIT_W'(par_q) + BIT_W'(stop2_q);
    assign mid_c        = presc_q >> 1;
    assign last_edge_c  = (edge_cnt_q == presc_q - PRESCALE_W'(1));
    assign last_bit_c   = (bit_cnt_q == frame_bits_c - BIT_W'(1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            cfg_err_q  <= 1'b0;
            len_q      <= LEN_W'(8);
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            presc_q    <= PRESCALE_W'(16);
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            cfg_err_q  <= cfg_err_d;
            len_q      <= len_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            presc_q    <= presc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        cfg_err_d    = cfg_err_q;
        len_d        = len_q;
        par_d        = par_q;
        stop2_d      = stop2_q;
        presc_d      = presc_q;
        sample_stb_c = 1'b0;
        sample_idx_c = '0;
        bit_done_c   = 1'b0;
        frame_done_c = 1'b0;

        // Strobes decode registered state only, independent of enable
        if (state_q == RUN) begin
            if (edge_cnt_q == mid_c - PRESCALE_W'(1)) begin
                sample_stb_c = 1'b1;
                sample_idx_c = IDX_W'(0);
            end else if (edge_cnt_q == mid_c) begin
                sample_stb_c = 1'b1;
                sample_idx_c = IDX_W'(1);
            end else if (edge_cnt_q == mid_c + PRESCALE_W'(1)) begin
                sample_stb_c = 1'b1;
                sample_idx_c = IDX_W'(2);
            end
            bit_done_c   = last_edge_c;
            frame_done_c = last_edge_c && last_bit_c;
        end

        if (!bt.enable) begin
            state_d    = IDLE;
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
            cfg_err_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    len_d      = bt.data_len;
                    par_d      = bt.PAR_EN;
                    stop2_d    = bt.STOP2;
                    presc_d    = bt.Prescale;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = cfg_ok_c ? RUN : ERR;
                    cfg_err_d  = !cfg_ok_c;
                end
                RUN: begin
                    if (last_edge_c) begin
                        edge_cnt_d = '0;
                        if (last_bit_c) begin
                            // Frame boundary: pick up the next frame's config
                            bit_cnt_d = '0;
                            len_d     = bt.data_len;
                            par_d     = bt.PAR_EN;
                            stop2_d   = bt.STOP2;
                            presc_d   = bt.Prescale;
                            if (!cfg_ok_c) begin
                                state_d   = ERR;
                                cfg_err_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        edge_cnt_d = edge_cnt_q + PRESCALE_W'(1);
                    end
                end
                ERR: begin
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cfg_err_d  = 1'b1;
                end
                default: begin
                    state_d    = IDLE;
                    edge_cnt_d = '0;
                    bit_cnt_d  = '0;
                    cfg_err_d  = 1'b0;
                end
            endcase
        end
    end

    assign bt.edge_cnt   = edge_cnt_q;
    assign bt.bit_cnt    = bit_cnt_q;
    assign bt.cfg_err    = cfg_err_q;
    assign bt.sample_stb = sample_stb_c;
    assign bt.sample_idx = sample_idx_c;
    assign bt.bit_done   = bit_done_c;
    assign bt.frame_done = frame_done_c;
endmodule
